// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer
// Single-clock first-word-fall-through FIFO. It buffers WIDTH-bit words between
// a producer (push/full handshake) and a consumer (pop/empty handshake).
//
// Ports
//   clk_i    : clock, all state changes on the rising edge
//   rst_i    : synchronous reset, active-high; clears pointers and count
//   push_i   : write request; data_i is stored when the push is accepted
//   data_i   : write data
//   full_o   : DEPTH entries stored
//   pop_i    : acknowledge of the presented head word; removes it
//   empty_o  : no entries stored
//   data_o   : head (oldest) word, forced to 0 while empty
//   count_o  : number of stored entries, 0..DEPTH
module sync_fifo_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic                       empty_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty;
  logic push_acc, pop_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A push while full is still accepted when the head is popped in the same
  // cycle: the pop frees the slot the new word lands in.
  assign push_acc = push_i & (~full | pop_i);
  assign pop_acc  = pop_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale words are never visible because
  // data_o is masked while empty and only written slots are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_acc) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sync_fifo_buffer.sv
module tb_sync_fifo_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             push_i;
  logic [WIDTH-1:0] data_i;
  logic             full_o;
  logic             pop_i;
  logic             empty_o;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    count_o;

  int checks = 0;
  int errors = 0;

  sync_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_i),
    .data_i  (data_i),
    .full_o  (full_o),
    .pop_i   (pop_i),
    .empty_o (empty_o),
    .data_o  (data_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    push_i = 1'b0;
    pop_i  = 1'b0;
    data_i = '0;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    push_i = 1'b1;
    pop_i  = 1'b0;
    data_i = 32'h5555_5555;
    tick();
    tick();
    rst_i = 1'b0;
    idle();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    tick();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_hold_count got %0d exp 0", count_o); end
  endtask

  task automatic test_single();
    push_i = 1'b1;
    data_i = 32'hDEAD_BEEF;
    tick();
    idle();
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty_o); end
    checks++; if (data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", data_o); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count_o); end
    pop_i = 1'b1;
    tick();
    idle();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b exp 1", empty_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL single_pop_data got %h exp 0", data_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      push_i = 1'b1;
      data_i = i;
      tick();
      if (i == DEPTH - 2) begin
        checks++; if (full_o !== 1'b0 || count_o !== 5'd15) begin errors++; $display("FAIL fill_15 got full=%b count=%0d exp full=0 count=15", full_o, count_o); end
      end
    end
    idle();
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", empty_o); end
    push_i = 1'b1;
    data_i = 32'h0000_FFFF;
    tick();
    idle();
    checks++; if (count_o !== 5'd16 || full_o !== 1'b1) begin errors++; $display("FAIL overflow_count got %0d full=%b exp 16 full=1", count_o, full_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL overflow_head got %h exp 0", data_o); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (data_o !== 32'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_o, 32'(i)); end
      pop_i = 1'b1;
      tick();
    end
    idle();
    checks++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty_o, count_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL drain_data_zero got %h exp 0", data_o); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < DEPTH; i++) begin
      push_i = 1'b1;
      data_i = 32'h200 + i;
      tick();
    end
    push_i = 1'b1;
    pop_i  = 1'b1;
    data_i = 32'h100;
    tick();
    idle();
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL simul_count got %0d exp 16", count_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL simul_full got %b exp 1", full_o); end
    checks++; if (data_o !== 32'h201) begin errors++; $display("FAIL simul_head got %h exp 201", data_o); end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [WIDTH-1:0] exp;
      exp = (i == DEPTH) ? 32'h100 : 32'h200 + i;
      checks++; if (data_o !== exp) begin errors++; $display("FAIL simul_drain[%0d] got %h exp %h", i, data_o, exp); end
      pop_i = 1'b1;
      tick();
    end
    idle();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL simul_end_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_underflow();
    push_i = 1'b1;
    pop_i  = 1'b1;
    data_i = 32'hA5A5_A5A5;
    tick();
    idle();
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL underflow_count got %0d exp 1", count_o); end
    checks++; if (data_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL underflow_data got %h exp a5a5a5a5", data_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL underflow_empty got %b exp 0", empty_o); end
    pop_i = 1'b1;
    tick();
    idle();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL underflow_drain got %b exp 1", empty_o); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_data;
    int pushes = 0;
    bit p, r, ap, ar;
    for (int c = 0; c < 120; c++) begin
      p = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 7);
      push_i = p;
      pop_i  = r;
      data_i = $urandom;
      ap = p && ((q.size() < DEPTH) || r);
      ar = r && (q.size() > 0);
      if (ar) void'(q.pop_front());
      if (ap) begin q.push_back(data_i); pushes++; end
      tick();
      exp_data = (q.size() > 0) ? q[0] : '0;
      checks++; if (data_o !== exp_data) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", c, data_o, exp_data); end
      checks++; if (count_o !== CW'(q.size())) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, count_o, q.size()); end
      checks++; if (full_o !== (q.size() == DEPTH)) begin errors++; $display("FAIL wrap_full[%0d] got %b exp %b", c, full_o, q.size() == DEPTH); end
      checks++; if (empty_o !== (q.size() == 0)) begin errors++; $display("FAIL wrap_empty[%0d] got %b exp %b", c, empty_o, q.size() == 0); end
    end
    idle();
    checks++; if (pushes < 2 * DEPTH) begin errors++; $display("FAIL wrap_coverage got %0d pushes exp at least %0d", pushes, 2 * DEPTH); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      push_i = 1'b1;
      data_i = 32'h300 + i;
      tick();
    end
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || data_o !== 32'h0) begin errors++; $display("FAIL mid_reset got count=%0d empty=%b data=%h exp 0 1 0", count_o, empty_o, data_o); end
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    #2;
    test_reset();
    test_single();
    test_fill_overflow();
    test_simul_full();
    test_underflow();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
